// File: rtl/axi_slave_mem_pkg.sv
// Shared encodings for the AXI slave memory: burst/response codes, FSM states
// and the request legality check used by both channels.
package axi_slave_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Only full-word transfers are supported; wrap bursts need a power-of-two beat count.
    function automatic logic req_legal(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic ok;
        ok = (size == SIZE_WORD) && (burst != 2'b11);
        if (burst == BURST_WRAP) begin
            ok = ok && ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 write/read channel bundle between a master and the slave memory.
interface axi_slave_mem_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 6
);
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [ID_W-1:0]   S_AXI_AWID;
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [7:0]        S_AXI_AWLEN;
    logic [2:0]        S_AXI_AWSIZE;
    logic [1:0]        S_AXI_AWBURST;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WLAST;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ID_W-1:0]   S_AXI_BID;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [ID_W-1:0]   S_AXI_ARID;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [7:0]        S_AXI_ARLEN;
    logic [2:0]        S_AXI_ARSIZE;
    logic [1:0]        S_AXI_ARBURST;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;
    logic [ID_W-1:0]   S_AXI_RID;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RLAST;

    modport slave (
        input  S_AXI_AWVALID, S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
        output S_AXI_AWREADY,
        input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
        output S_AXI_WREADY,
        input  S_AXI_BREADY,
        output S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP,
        input  S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
        output S_AXI_ARREADY,
        input  S_AXI_RREADY,
        output S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST
    );

    modport master (
        output S_AXI_AWVALID, S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
        input  S_AXI_AWREADY,
        output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
        input  S_AXI_WREADY,
        output S_AXI_BREADY,
        input  S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP,
        output S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
        input  S_AXI_ARREADY,
        output S_AXI_RREADY,
        input  S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST
    );
endinterface

// File: rtl/axi_slave_mem_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts of 32-bit words.
module axi_slave_mem_addr_gen
    import axi_slave_mem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);
    logic [ADDR_W-1:0] incr_s;
    logic [ADDR_W-1:0] mask_s;

    // For legal wrap lengths (len+1)*4-1 is simply {len, 2'b11}.
    assign mask_s = ADDR_W'({len_i, 2'b11});
    assign incr_s = addr_i + ADDR_W'(4);

    // Select the address update rule for the burst type.
    always_comb begin
        next_addr_o = addr_i;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_s;
            BURST_WRAP:  next_addr_o = (addr_i & ~mask_s) | (incr_s & mask_s);
            default:     next_addr_o = addr_i;
        endcase
    end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a small word memory; independent write and read FSMs
// share the array, a read load in the same cycle as a write sees the old word.
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    axi_slave_mem_if.slave s_axi
);
    localparam int DEPTH  = (1 << ADDR_W) / 4;
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    w_state_e          w_q, w_d;
    logic [ID_W-1:0]   awid_q, bid_q;
    logic [ADDR_W-1:0] waddr_q, waddr_nxt_s;
    logic [7:0]        awlen_q;
    logic [1:0]        awburst_q, bresp_q;
    logic              wbad_q;
    logic [8:0]        wbeat_q;
    logic              aw_hs_s, w_hs_s, wr_en_s;

    r_state_e          r_q, r_d;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] raddr_q, rgen_addr_s, raddr_nxt_s;
    logic [7:0]        arlen_q, rgen_len_s, rbeat_q;
    logic [1:0]        arburst_q, rgen_burst_s, rresp_q;
    logic              rbad_q, rlast_q, ar_legal_s, ar_hs_s, r_hs_s;
    logic [DATA_W-1:0] rdata_q;

    assign aw_hs_s = (w_q == W_IDLE) && s_axi.S_AXI_AWVALID;
    assign w_hs_s  = (w_q == W_DATA) && s_axi.S_AXI_WVALID;
    // Beats past AWLEN are accepted but dropped; the counter saturates at 256.
    assign wr_en_s = w_hs_s && !wbad_q && (wbeat_q <= {1'b0, awlen_q});

    axi_slave_mem_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
        .addr_i(waddr_q), .len_i(awlen_q), .burst_i(awburst_q), .next_addr_o(waddr_nxt_s)
    );

    // Write FSM next state.
    always_comb begin
        w_d = w_q;
        case (w_q)
            W_IDLE:  if (aw_hs_s) w_d = W_DATA; else w_d = W_IDLE;
            W_DATA:  if (w_hs_s && s_axi.S_AXI_WLAST) w_d = W_RESP; else w_d = W_DATA;
            W_RESP:  if (s_axi.S_AXI_BREADY) w_d = W_IDLE; else w_d = W_RESP;
            default: w_d = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_q <= W_IDLE;
        else       w_q <= w_d;
    end

    // Write burst context, beat counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awid_q <= '0; waddr_q <= '0; awlen_q <= 8'd0; awburst_q <= 2'b00;
            wbad_q <= 1'b0; wbeat_q <= 9'd0; bresp_q <= RESP_OKAY; bid_q <= '0;
        end else if (aw_hs_s) begin
            awid_q    <= s_axi.S_AXI_AWID;
            waddr_q   <= s_axi.S_AXI_AWADDR;
            awlen_q   <= s_axi.S_AXI_AWLEN;
            awburst_q <= s_axi.S_AXI_AWBURST;
            wbad_q    <= !req_legal(s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWLEN);
            wbeat_q   <= 9'd0;
        end else if (w_hs_s) begin
            waddr_q <= waddr_nxt_s;
            wbeat_q <= wbeat_q[8] ? wbeat_q : wbeat_q + 9'd1;
            if (s_axi.S_AXI_WLAST) begin
                bid_q   <= awid_q;
                bresp_q <= (!wbad_q && (wbeat_q == {1'b0, awlen_q})) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Byte-enabled memory write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem_q[waddr_q[ADDR_W-1:2]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign ar_hs_s    = (r_q == R_IDLE) && s_axi.S_AXI_ARVALID;
    assign r_hs_s     = (r_q == R_DATA) && s_axi.S_AXI_RREADY;
    assign ar_legal_s = req_legal(s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARLEN);

    // While idle the generator works on the incoming request so beat 1 is ready at once.
    assign rgen_addr_s  = (r_q == R_IDLE) ? s_axi.S_AXI_ARADDR  : raddr_q;
    assign rgen_len_s   = (r_q == R_IDLE) ? s_axi.S_AXI_ARLEN   : arlen_q;
    assign rgen_burst_s = (r_q == R_IDLE) ? s_axi.S_AXI_ARBURST : arburst_q;

    axi_slave_mem_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
        .addr_i(rgen_addr_s), .len_i(rgen_len_s), .burst_i(rgen_burst_s), .next_addr_o(raddr_nxt_s)
    );

    // Read FSM next state.
    always_comb begin
        r_d = r_q;
        case (r_q)
            R_IDLE:  if (ar_hs_s) r_d = R_DATA; else r_d = R_IDLE;
            R_DATA:  if (r_hs_s && rlast_q) r_d = R_IDLE; else r_d = R_DATA;
            default: r_d = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= R_IDLE;
        else       r_q <= r_d;
    end

    // Read burst context and registered R channel outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rid_q <= '0; raddr_q <= '0; arlen_q <= 8'd0; arburst_q <= 2'b00; rbad_q <= 1'b0;
            rbeat_q <= 8'd0; rdata_q <= '0; rresp_q <= RESP_OKAY; rlast_q <= 1'b0;
        end else if (ar_hs_s) begin
            rid_q     <= s_axi.S_AXI_ARID;
            arlen_q   <= s_axi.S_AXI_ARLEN;
            arburst_q <= s_axi.S_AXI_ARBURST;
            rbad_q    <= !ar_legal_s;
            raddr_q   <= raddr_nxt_s;
            rbeat_q   <= 8'd1;
            rdata_q   <= ar_legal_s ? mem_q[s_axi.S_AXI_ARADDR[ADDR_W-1:2]] : '0;
            rresp_q   <= ar_legal_s ? RESP_OKAY : RESP_SLVERR;
            rlast_q   <= (s_axi.S_AXI_ARLEN == 8'd0);
        end else if (r_hs_s && !rlast_q) begin
            raddr_q <= raddr_nxt_s;
            rbeat_q <= rbeat_q + 8'd1;
            rdata_q <= rbad_q ? '0 : mem_q[raddr_q[ADDR_W-1:2]];
            rlast_q <= (rbeat_q == arlen_q);
        end
    end

    assign s_axi.S_AXI_AWREADY = (w_q == W_IDLE);
    assign s_axi.S_AXI_WREADY  = (w_q == W_DATA);
    assign s_axi.S_AXI_BVALID  = (w_q == W_RESP);
    assign s_axi.S_AXI_BID     = bid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = (r_q == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_q == R_DATA);
    assign s_axi.S_AXI_RID     = rid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed, table-driven bench for axi_slave_mem plus hand sequences for
// stalls, same-cycle read/write and reset in the middle of a write burst.
module tb_axi_slave_mem;
    import axi_slave_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_slave_mem_if #(.ID_W(6), .ADDR_W(6)) bus ();
    axi_slave_mem #(.ID_W(6), .ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .reset(rst), .s_axi(bus.slave)
    );

    typedef struct {
        logic             is_wr;
        logic [5:0]       id;
        logic [5:0]       addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [2:0]       size;
        int               nb;
        logic [3:0]       strb;
        logic [1:0]       resp;
        logic [3:0][31:0] d;
    } vec_t;

    vec_t vecs[23];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [5:0] id, input logic [5:0] a,
                                input logic [7:0] l, input logic [1:0] b, input logic [2:0] s,
                                input int nb, input logic [3:0] st, input logic [1:0] r,
                                input logic [3:0][31:0] d);
        vec_t v;
        v.is_wr = w; v.id = id; v.addr = a; v.len = l; v.burst = b; v.size = s;
        v.nb = nb; v.strb = st; v.resp = r; v.d = d;
        return v;
    endfunction

    task automatic wait_awready();
        for (int t = 0; t < 20 && !bus.S_AXI_AWREADY; t++) @(negedge clk);
    endtask

    task automatic axi_write(input string nm, input vec_t v);
        @(negedge clk);
        bus.S_AXI_AWID = v.id; bus.S_AXI_AWADDR = v.addr; bus.S_AXI_AWLEN = v.len;
        bus.S_AXI_AWSIZE = v.size; bus.S_AXI_AWBURST = v.burst; bus.S_AXI_AWVALID = 1'b1;
        wait_awready();
        chk({nm, " awready"}, 32'(bus.S_AXI_AWREADY), 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = v.d[b]; bus.S_AXI_WSTRB = v.strb;
            bus.S_AXI_WLAST = (b == v.nb - 1);
            for (int t = 0; t < 20 && !bus.S_AXI_WREADY; t++) @(negedge clk);
            chk($sformatf("%s wready%0d", nm, b), 32'(bus.S_AXI_WREADY), 32'd1);
            @(negedge clk);
        end
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_BREADY = 1'b1;
        for (int t = 0; t < 20 && !bus.S_AXI_BVALID; t++) @(negedge clk);
        chk({nm, " bvalid"}, 32'(bus.S_AXI_BVALID), 32'd1);
        chk({nm, " bresp"}, 32'(bus.S_AXI_BRESP), 32'(v.resp));
        chk({nm, " bid"}, 32'(bus.S_AXI_BID), 32'(v.id));
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk({nm, " bvalid_drop"}, 32'(bus.S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input string nm, input vec_t v);
        @(negedge clk);
        bus.S_AXI_ARID = v.id; bus.S_AXI_ARADDR = v.addr; bus.S_AXI_ARLEN = v.len;
        bus.S_AXI_ARSIZE = v.size; bus.S_AXI_ARBURST = v.burst; bus.S_AXI_ARVALID = 1'b1;
        for (int t = 0; t < 20 && !bus.S_AXI_ARREADY; t++) @(negedge clk);
        chk({nm, " arready"}, 32'(bus.S_AXI_ARREADY), 32'd1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
        for (int b = 0; b <= int'(v.len); b++) begin
            chk($sformatf("%s rvalid%0d", nm, b), 32'(bus.S_AXI_RVALID), 32'd1);
            chk($sformatf("%s rdata%0d", nm, b), bus.S_AXI_RDATA, v.d[b]);
            chk($sformatf("%s rresp%0d", nm, b), 32'(bus.S_AXI_RRESP), 32'(v.resp));
            chk($sformatf("%s rlast%0d", nm, b), 32'(bus.S_AXI_RLAST), 32'(b == int'(v.len)));
            chk($sformatf("%s rid%0d", nm, b), 32'(bus.S_AXI_RID), 32'(v.id));
            @(negedge clk);
        end
        bus.S_AXI_RREADY = 1'b0;
        chk({nm, " rvalid_drop"}, 32'(bus.S_AXI_RVALID), 32'd0);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " awready"}, 32'(bus.S_AXI_AWREADY), 32'd1);
        chk({nm, " arready"}, 32'(bus.S_AXI_ARREADY), 32'd1);
        chk({nm, " bvalid"}, 32'(bus.S_AXI_BVALID), 32'd0);
        chk({nm, " rvalid"}, 32'(bus.S_AXI_RVALID), 32'd0);
        chk({nm, " rlast"}, 32'(bus.S_AXI_RLAST), 32'd0);
        chk({nm, " rdata"}, bus.S_AXI_RDATA, 32'd0);
        chk({nm, " bresp"}, 32'(bus.S_AXI_BRESP), 32'd0);
        chk({nm, " rresp"}, 32'(bus.S_AXI_RRESP), 32'd0);
        chk({nm, " bid"}, 32'(bus.S_AXI_BID), 32'd0);
        chk({nm, " rid"}, 32'(bus.S_AXI_RID), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = 8'd0;
        bus.S_AXI_AWSIZE = 3'd0; bus.S_AXI_AWBURST = 2'd0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WDATA = 32'd0; bus.S_AXI_WSTRB = 4'd0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARID = '0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARSIZE = 3'd0;
        bus.S_AXI_ARBURST = 2'd0; bus.S_AXI_RREADY = 1'b0;

        vecs[0]  = mk(1'b1, 6'd1,  6'h00, 8'd3, BURST_INCR,  3'd2, 4, 4'hF, RESP_OKAY,   {32'h44, 32'h33, 32'h22, 32'h11});
        vecs[1]  = mk(1'b0, 6'd2,  6'h00, 8'd3, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h44, 32'h33, 32'h22, 32'h11});
        vecs[2]  = mk(1'b1, 6'd3,  6'h3C, 8'd0, BURST_INCR,  3'd2, 1, 4'hF, RESP_OKAY,   {32'h0, 32'h0, 32'h0, 32'h44});
        vecs[3]  = mk(1'b1, 6'd4,  6'h3C, 8'd0, BURST_INCR,  3'd2, 1, 4'h3, RESP_OKAY,   {32'h0, 32'h0, 32'h0, 32'hAABBCCDD});
        vecs[4]  = mk(1'b0, 6'd5,  6'h3C, 8'd0, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'h0, 32'h0000CCDD});
        vecs[5]  = mk(1'b0, 6'd6,  6'h08, 8'd3, BURST_WRAP,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h22, 32'h11, 32'h44, 32'h33});
        vecs[6]  = mk(1'b0, 6'd7,  6'h3C, 8'd1, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'h11, 32'h0000CCDD});
        vecs[7]  = mk(1'b0, 6'd8,  6'h00, 8'd1, BURST_INCR,  3'd1, 0, 4'h0, RESP_SLVERR, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[8]  = mk(1'b1, 6'd9,  6'h10, 8'd3, BURST_INCR,  3'd2, 2, 4'hF, RESP_SLVERR, {32'h0, 32'h0, 32'hDEAD0002, 32'hDEAD0001});
        vecs[9]  = mk(1'b0, 6'd10, 6'h10, 8'd1, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'hDEAD0002, 32'hDEAD0001});
        vecs[10] = mk(1'b1, 6'd11, 6'h00, 8'd0, 2'b11,       3'd2, 1, 4'hF, RESP_SLVERR, {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF});
        vecs[11] = mk(1'b0, 6'd12, 6'h00, 8'd0, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'h0, 32'h11});
        vecs[12] = mk(1'b1, 6'd13, 6'h20, 8'd1, BURST_FIXED, 3'd2, 2, 4'hF, RESP_OKAY,   {32'h0, 32'h0, 32'h2, 32'h1});
        vecs[13] = mk(1'b0, 6'd14, 6'h20, 8'd1, BURST_FIXED, 3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'h2, 32'h2});
        vecs[14] = mk(1'b1, 6'd15, 6'h24, 8'd1, BURST_INCR,  3'd2, 3, 4'hF, RESP_SLVERR, {32'h0, 32'hC, 32'hB, 32'hA});
        vecs[15] = mk(1'b0, 6'd16, 6'h24, 8'd2, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'hB, 32'hA});
        vecs[16] = mk(1'b1, 6'd17, 6'h34, 8'd3, BURST_WRAP,  3'd2, 4, 4'hF, RESP_OKAY,   {32'h4, 32'h3, 32'h2, 32'h1});
        vecs[17] = mk(1'b0, 6'd18, 6'h30, 8'd3, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h3, 32'h2, 32'h1, 32'h4});
        vecs[18] = mk(1'b0, 6'd19, 6'h30, 8'd2, BURST_WRAP,  3'd2, 0, 4'h0, RESP_SLVERR, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[19] = mk(1'b1, 6'd20, 6'h00, 8'd2, BURST_WRAP,  3'd2, 3, 4'hF, RESP_SLVERR, {32'h0, 32'h99, 32'h99, 32'h99});
        vecs[20] = mk(1'b0, 6'd21, 6'h00, 8'd0, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'h0, 32'h11});
        vecs[21] = mk(1'b1, 6'd22, 6'h20, 8'd0, BURST_INCR,  3'd2, 1, 4'hC, RESP_OKAY,   {32'h0, 32'h0, 32'h0, 32'hA5A5A5A5});
        vecs[22] = mk(1'b0, 6'd23, 6'h20, 8'd0, BURST_INCR,  3'd2, 0, 4'h0, RESP_OKAY,   {32'h0, 32'h0, 32'h0, 32'hA5A50002});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        for (int i = 0; i < 23; i++) begin
            if (vecs[i].is_wr) axi_write($sformatf("v%0d", i), vecs[i]);
            else               axi_read($sformatf("v%0d", i), vecs[i]);
        end

        // RREADY low for three cycles on beat 1: output must hold.
        @(negedge clk);
        bus.S_AXI_ARID = 6'd30; bus.S_AXI_ARADDR = 6'h00; bus.S_AXI_ARLEN = 8'd3;
        bus.S_AXI_ARSIZE = 3'd2; bus.S_AXI_ARBURST = BURST_INCR; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
        chk("stall b0", bus.S_AXI_RDATA, 32'h11);
        @(negedge clk);
        chk("stall b1", bus.S_AXI_RDATA, 32'h22);
        bus.S_AXI_RREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall hold%0d rdata", k), bus.S_AXI_RDATA, 32'h22);
            chk($sformatf("stall hold%0d rvalid", k), 32'(bus.S_AXI_RVALID), 32'd1);
            chk($sformatf("stall hold%0d rlast", k), 32'(bus.S_AXI_RLAST), 32'd0);
        end
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        chk("stall b2", bus.S_AXI_RDATA, 32'h33);
        @(negedge clk);
        chk("stall b3", bus.S_AXI_RDATA, 32'h44);
        chk("stall b3 rlast", 32'(bus.S_AXI_RLAST), 32'd1);
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        chk("stall done", 32'(bus.S_AXI_RVALID), 32'd0);

        // Write beat and AR load of the same word in one cycle: read gets the old word.
        @(negedge clk);
        bus.S_AXI_AWID = 6'd31; bus.S_AXI_AWADDR = 6'h00; bus.S_AXI_AWLEN = 8'd0;
        bus.S_AXI_AWSIZE = 3'd2; bus.S_AXI_AWBURST = BURST_INCR; bus.S_AXI_AWVALID = 1'b1;
        chk("same awready", 32'(bus.S_AXI_AWREADY), 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'h77777777; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_WLAST = 1'b1;
        bus.S_AXI_ARID = 6'd32; bus.S_AXI_ARADDR = 6'h00; bus.S_AXI_ARLEN = 8'd0;
        bus.S_AXI_ARSIZE = 3'd2; bus.S_AXI_ARBURST = BURST_INCR; bus.S_AXI_ARVALID = 1'b1;
        chk("same wready", 32'(bus.S_AXI_WREADY), 32'd1);
        chk("same arready", 32'(bus.S_AXI_ARREADY), 32'd1);
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
        chk("same rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
        chk("same rdata old", bus.S_AXI_RDATA, 32'h11);
        chk("same bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
        chk("same bresp", 32'(bus.S_AXI_BRESP), 32'(RESP_OKAY));
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        axi_read("same new", mk(1'b0, 6'd33, 6'h00, 8'd0, BURST_INCR, 3'd2, 0, 4'h0, RESP_OKAY,
                                {32'h0, 32'h0, 32'h0, 32'h77777777}));

        // Reset in the middle of a write burst.
        @(negedge clk);
        bus.S_AXI_AWID = 6'd34; bus.S_AXI_AWADDR = 6'h10; bus.S_AXI_AWLEN = 8'd3;
        bus.S_AXI_AWSIZE = 3'd2; bus.S_AXI_AWBURST = BURST_INCR; bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        bus.S_AXI_WVALID = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("midrst");
        bus.S_AXI_BREADY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("midrst nob%0d", k), 32'(bus.S_AXI_BVALID), 32'd0);
        end
        bus.S_AXI_BREADY = 1'b0;
        axi_read("midrst mem", mk(1'b0, 6'd35, 6'h10, 8'd1, BURST_INCR, 3'd2, 0, 4'h0, RESP_OKAY,
                                  {32'h0, 32'h0, 32'h0, 32'h0}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter ID_W, default 6, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 6, byte-address width; memory depth = 2^ADDR_W/4 words (16).
REQ-003 SHALL have parameter DATA_W, default 32, data width; only 32 supported.
REQ-004 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 S_AXI_AWVALID/AWREADY  in/out  1/1  AW handshake; S_AXI_AWID in ID_W, S_AXI_AWADDR in ADDR_W, S_AXI_AWLEN in 8, S_AXI_AWSIZE in 3, S_AXI_AWBURST in 2.
REQ-008 S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WLAST in 1: write data.
REQ-009 S_AXI_BVALID out 1, S_AXI_BREADY in 1, S_AXI_BID out ID_W, S_AXI_BRESP out 2: write response.
REQ-010 S_AXI_ARVALID/ARREADY in/out 1/1; S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST in, same widths as AW.
REQ-011 S_AXI_RVALID out 1, S_AXI_RREADY in 1, S_AXI_RID out ID_W, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RLAST out 1: read data.

Function
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE; WREADY=1 only in W_DATA; BVALID=1 only in W_RESP.
REQ-013 AW handshake SHALL latch ID/ADDR/LEN/BURST, clear beat counter, go W_DATA next cycle.
REQ-014 Each W handshake SHALL write bytes of word addr[ADDR_W-1:2] whose WSTRB bit is 1, then advance address.
REQ-015 W handshake with WLAST=1 SHALL go W_RESP; BRESP=OKAY(00) if beat count==AWLEN, else SLVERR(10); beats beyond AWLEN SHALL not be written.
REQ-016 W_RESP SHALL hold BID/BRESP stable until BREADY, then return to W_IDLE.
REQ-017 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-018 AR handshake in cycle N SHALL give RVALID=1 with beat-0 data in cycle N+1.
REQ-019 RDATA/RRESP/RLAST/RID SHALL be registered and stable while RVALID && !RREADY.
REQ-020 R handshake on a non-last beat SHALL present next beat in the following cycle (no bubble); RLAST=1 exactly on beat ARLEN; handshake on RLAST returns to R_IDLE.
REQ-021 Address update: FIXED(00) unchanged; INCR(01) +4 modulo 2^ADDR_W; WRAP(10) +4 within boundary aligned to (LEN+1)*4.
REQ-022 Illegal request (AxSIZE!=010, AxBURST==11, or WRAP with LEN not in {1,3,7,15}) SHALL complete full handshake sequence without memory writes; BRESP=SLVERR; every R beat RDATA=0, RRESP=SLVERR.
REQ-023 Read and write channels SHALL operate concurrently; same-cycle write and read-beat load of one word SHALL return the old value.
REQ-024 Outputs not named valid SHALL hold last value when idle.

Reset
REQ-025 Reset SHALL force W_IDLE, R_IDLE, all memory words 0, BVALID=RVALID=RLAST=0, BRESP=RRESP=00, BID=RID=0, RDATA=0.
REQ-026 Reset asserted mid-burst SHALL abort the transaction immediately; no response issued after release.
REQ-027 AWREADY and ARREADY SHALL be 1 in first cycle after reset release.

Structure
REQ-028 Package axi_slave_mem_pkg SHALL hold BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, write and read state encodings.
REQ-029 Sub-module axi_slave_mem_addr_gen (combinational next-address from addr, len, burst) SHALL be instantiated once per channel.

Verification
REQ-030 INCR AW addr=0x00 len=3, data 0x11..0x44, WSTRB=F -> BRESP=00; INCR read addr=0x00 len=3 -> 0x11,0x22,0x33,0x44, RLAST on 4th.
REQ-031 WSTRB=0011 data 0xAABBCCDD to word 0x3C containing 0x44 -> read 0x0000CCDD.
REQ-032 WRAP read addr=0x08 len=3 -> words at 0x08,0x0C,0x00,0x04.
REQ-033 INCR read addr=0x3C len=1 -> words 0x3C then 0x00 (wrap-around).
REQ-034 ARSIZE=001 len=1 -> two beats RDATA=0 RRESP=10; WLAST on beat 1 with AWLEN=3 -> BRESP=10.
REQ-035 RREADY held 0 for 3 cycles mid-burst -> RDATA stable; reset mid-write -> AWREADY=1 after release, no BVALID.
